// File: rtl/usb_rx_byte_assembler.sv
// USB receive front end: bit-timing recovery, NRZI decode, bit unstuffing,
// SYNC check, LSB-first byte assembly with FIFO write strobe, EOP detection
// and sticky error reporting.
// Optional build macro RX_RESYNC_EN: realign the bit timer on every d_plus
// transition while in SYNC/RECEIVE.
module usb_rx_byte_assembler #(
  parameter int unsigned CLKS_PER_BIT = 8,
  parameter logic [7:0]  SYNC_BYTE    = 8'h80,
  parameter int unsigned STUFF_LIMIT  = 6
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       d_plus,
  input  logic       d_minus,
  input  logic       fifo_full,
  output logic       w_enable,
  output logic [7:0] w_data,
  output logic       rcving,
  output logic       r_error,
  output logic       packet_done
);

  localparam int unsigned   TW       = $clog2(CLKS_PER_BIT);
  localparam int unsigned   OW       = $clog2(STUFF_LIMIT + 1);
  localparam logic [TW-1:0] HalfLoad = TW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [TW-1:0] FullLoad = TW'(CLKS_PER_BIT - 1);
  localparam logic [OW-1:0] OnesMax  = OW'(STUFF_LIMIT);

  typedef enum logic [2:0] {StIdle, StSync, StReceive, StEop, StErr} state_e;

  state_e        state_q;
  logic          prev_q;      // d_plus at the previous bit sample
  logic          edge_q;      // d_plus one clock ago
  logic [TW-1:0] timer_q;
  logic [7:0]    shift_q;
  logic [OW-1:0] ones_q;
  logic [2:0]    cnt_q;
  logic          se0_seen_q;  // EOP: second SE0 seen; ERR: last sample was SE0
  logic          w_enable_q;
  logic [7:0]    w_data_q;
  logic          rcving_q;
  logic          r_error_q;
  logic          packet_done_q;

  logic       sample;
  logic       line_se0;
  logic       line_j;
  logic       nrzi_bit;
  logic       stuff_slot;
  logic       byte_done;
  logic [7:0] next_byte;

  // Line decode and per-sample bit decisions.
  always_comb begin
    sample     = (timer_q == '0);
    line_se0   = (d_plus == d_minus);  // both-high is handled as SE0
    line_j     = d_plus & ~d_minus;
    nrzi_bit   = (d_plus == prev_q);
    stuff_slot = (ones_q == OnesMax);
    byte_done  = (cnt_q == 3'd7);
    next_byte  = {nrzi_bit, shift_q[7:1]};
  end

  // Receiver FSM with registered outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= StIdle;
      prev_q        <= 1'b1;
      edge_q        <= 1'b1;
      timer_q       <= '0;
      shift_q       <= '0;
      ones_q        <= '0;
      cnt_q         <= '0;
      se0_seen_q    <= 1'b0;
      w_enable_q    <= 1'b0;
      w_data_q      <= '0;
      rcving_q      <= 1'b0;
      r_error_q     <= 1'b0;
      packet_done_q <= 1'b0;
    end else begin
      edge_q        <= d_plus;
      w_enable_q    <= 1'b0;
      packet_done_q <= 1'b0;
      if (state_q != StIdle) begin
        timer_q <= sample ? FullLoad : timer_q - TW'(1);
      end
`ifdef RX_RESYNC_EN
      if ((state_q == StSync || state_q == StReceive) && (edge_q != d_plus)) begin
        timer_q <= HalfLoad;
      end
`endif
      case (state_q)
        StIdle: begin
          if (edge_q && !d_plus) begin
            state_q   <= StSync;
            timer_q   <= HalfLoad;
            prev_q    <= 1'b1;
            shift_q   <= '0;
            ones_q    <= '0;
            cnt_q     <= '0;
            rcving_q  <= 1'b1;
            r_error_q <= 1'b0;
          end
        end
        StSync, StReceive: begin
          if (sample) begin
            prev_q <= d_plus;
            if (line_se0) begin
              if (state_q == StReceive && cnt_q == 3'd0) begin
                state_q    <= StEop;
                se0_seen_q <= 1'b0;
              end else begin
                // SE0 inside SYNC or mid-byte: the partial byte is dropped
                state_q    <= StErr;
                r_error_q  <= 1'b1;
                se0_seen_q <= 1'b1;
              end
            end else if (stuff_slot) begin
              ones_q <= '0;
              if (nrzi_bit) begin
                state_q    <= StErr;
                r_error_q  <= 1'b1;
                se0_seen_q <= 1'b0;
              end
            end else begin
              ones_q  <= nrzi_bit ? ones_q + OW'(1) : '0;
              shift_q <= next_byte;
              cnt_q   <= cnt_q + 3'd1;
              if (byte_done) begin
                if (state_q == StSync) begin
                  if (next_byte == SYNC_BYTE) begin
                    state_q <= StReceive;
                  end else begin
                    state_q    <= StErr;
                    r_error_q  <= 1'b1;
                    se0_seen_q <= 1'b0;
                  end
                end else if (fifo_full) begin
                  state_q    <= StErr;
                  r_error_q  <= 1'b1;
                  se0_seen_q <= 1'b0;
                end else begin
                  w_data_q   <= next_byte;
                  w_enable_q <= 1'b1;
                end
              end
            end
          end
        end
        StEop: begin
          if (sample) begin
            prev_q <= d_plus;
            if (line_j) begin
              packet_done_q <= 1'b1;
              rcving_q      <= 1'b0;
              state_q       <= StIdle;
            end else if (line_se0 && !se0_seen_q) begin
              se0_seen_q <= 1'b1;
            end else begin
              // K, or a third SE0 bit time
              state_q    <= StErr;
              r_error_q  <= 1'b1;
              se0_seen_q <= line_se0;
            end
          end
        end
        StErr: begin
          if (sample) begin
            prev_q <= d_plus;
            if (line_se0) begin
              se0_seen_q <= 1'b1;
            end else if (line_j && se0_seen_q) begin
              state_q  <= StIdle;
              rcving_q <= 1'b0;
            end else begin
              se0_seen_q <= 1'b0;
            end
          end
        end
        default: begin
          state_q  <= StIdle;
          rcving_q <= 1'b0;
        end
      endcase
    end
  end

  assign w_enable    = w_enable_q;
  assign w_data      = w_data_q;
  assign rcving      = rcving_q;
  assign r_error     = r_error_q;
  assign packet_done = packet_done_q;

endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// Self-checking bench for usb_rx_byte_assembler: packets are built as decoded
// bit streams, bit-stuffed and NRZI-encoded here, and the received bytes,
// EOP pulses and error flag are compared with what the packet should yield.
module tb_usb_rx_byte_assembler;

  localparam int CPB = 8;
  localparam logic [7:0] SYNC = 8'h80;

  logic       clk;
  logic       n_rst;
  logic       d_plus;
  logic       d_minus;
  logic       fifo_full;
  logic       w_enable;
  logic [7:0] w_data;
  logic       rcving;
  logic       r_error;
  logic       packet_done;

  int tests = 0;
  int fails = 0;

  logic [7:0] got_q[$];   // bytes seen on the write strobe
  logic [7:0] exp_q[$];   // bytes of the packet being sent
  logic       bits_q[$];  // decoded bits before stuffing
  logic       wire_q[$];  // bits on the wire after stuffing
  int         done_cnt = 0;
  int         both_cnt = 0;
  logic       sop_rcving;
  logic       sop_rerror;

  usb_rx_byte_assembler dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .d_plus      (d_plus),
    .d_minus     (d_minus),
    .fifo_full   (fifo_full),
    .w_enable    (w_enable),
    .w_data      (w_data),
    .rcving      (rcving),
    .r_error     (r_error),
    .packet_done (packet_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observe outputs on the falling edge.
  always @(negedge clk) begin
    if (w_enable) got_q.push_back(w_data);
    if (packet_done) done_cnt++;
    if (w_enable && packet_done) both_cnt++;
  end

  task automatic add_byte(input logic [7:0] b);
    for (int i = 0; i < 8; i++) bits_q.push_back(b[i]);
  endtask

  // Insert a 0 after every run of six 1s.
  task automatic stuff_stream();
    int ones;
    ones = 0;
    wire_q.delete();
    foreach (bits_q[i]) begin
      wire_q.push_back(bits_q[i]);
      if (bits_q[i]) begin
        ones++;
        if (ones == 6) begin
          wire_q.push_back(1'b0);
          ones = 0;
        end
      end else begin
        ones = 0;
      end
    end
  endtask

  // NRZI-drive wire_q starting from J; nbits < 0 sends everything.
  task automatic send_wire(input int nbits);
    logic lvl;
    int   n;
    lvl = 1'b1;
    n = (nbits < 0) ? wire_q.size() : nbits;
    for (int i = 0; i < n; i++) begin
      if (!wire_q[i]) lvl = ~lvl;
      d_plus  = lvl;
      d_minus = ~lvl;
      repeat (CPB) @(negedge clk);
      if (i == 0) begin
        sop_rcving = rcving;
        sop_rerror = r_error;
      end
    end
  endtask

  task automatic send_eop();
    d_plus = 1'b0; d_minus = 1'b0;
    repeat (2 * CPB) @(negedge clk);
    d_plus = 1'b1; d_minus = 1'b0;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic idle(input int clks);
    d_plus = 1'b1; d_minus = 1'b0;
    repeat (clks) @(negedge clk);
  endtask

  // Build SYNC + exp_q, stuff, send, and finish with EOP.
  task automatic send_packet();
    bits_q.delete();
    add_byte(SYNC);
    foreach (exp_q[i]) add_byte(exp_q[i]);
    stuff_stream();
    got_q.delete();
    send_wire(-1);
    send_eop();
  endtask

  task automatic test_reset();
    n_rst = 1'b0;
    repeat (2) @(negedge clk);
    tests++; if (w_enable !== 1'b0) begin fails++; $display("FAIL rst_w_enable: got %b want 0", w_enable); end
    tests++; if (w_data !== 8'h00) begin fails++; $display("FAIL rst_w_data: got %h want 00", w_data); end
    tests++; if (rcving !== 1'b0) begin fails++; $display("FAIL rst_rcving: got %b want 0", rcving); end
    tests++; if (r_error !== 1'b0) begin fails++; $display("FAIL rst_r_error: got %b want 0", r_error); end
    tests++; if (packet_done !== 1'b0) begin fails++; $display("FAIL rst_packet_done: got %b want 0", packet_done); end
    n_rst = 1'b1;
    idle(20);
    tests++; if (rcving !== 1'b0) begin fails++; $display("FAIL idle_rcving: got %b want 0", rcving); end
  endtask

  task automatic test_basic();
    int d0;
    exp_q = '{8'hA5};
    d0 = done_cnt;
    send_packet();
    tests++; if (sop_rcving !== 1'b1) begin fails++; $display("FAIL basic_sop_rcving: got %b want 1", sop_rcving); end
    tests++; if (got_q.size() != 1) begin fails++; $display("FAIL basic_nwrites: got %0d want 1", got_q.size()); end
    else begin
      tests++; if (got_q[0] !== 8'hA5) begin fails++; $display("FAIL basic_data: got %h want a5", got_q[0]); end
    end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL basic_done: got %0d want 1", done_cnt - d0); end
    tests++; if (rcving !== 1'b0) begin fails++; $display("FAIL basic_rcving: got %b want 0", rcving); end
    tests++; if (r_error !== 1'b0) begin fails++; $display("FAIL basic_r_error: got %b want 0", r_error); end
    idle(10);
  endtask

  task automatic test_stuffing();
    int d0;
    exp_q = '{8'hFF, 8'h00};
    d0 = done_cnt;
    send_packet();
    tests++; if (wire_q.size() != 25) begin fails++; $display("FAIL stuff_len: got %0d want 25", wire_q.size()); end
    tests++; if (got_q.size() != 2) begin fails++; $display("FAIL stuff_nwrites: got %0d want 2", got_q.size()); end
    else begin
      tests++; if (got_q[0] !== 8'hFF) begin fails++; $display("FAIL stuff_b0: got %h want ff", got_q[0]); end
      tests++; if (got_q[1] !== 8'h00) begin fails++; $display("FAIL stuff_b1: got %h want 00", got_q[1]); end
    end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL stuff_done: got %0d want 1", done_cnt - d0); end
    tests++; if (r_error !== 1'b0) begin fails++; $display("FAIL stuff_r_error: got %b want 0", r_error); end
    idle(10);
  endtask

  task automatic test_stuff_error();
    int d0;
    bits_q.delete();
    add_byte(SYNC);
    for (int i = 0; i < 7; i++) bits_q.push_back(1'b1);
    wire_q = bits_q;  // deliberately unstuffed
    got_q.delete();
    d0 = done_cnt;
    send_wire(-1);
    tests++; if (r_error !== 1'b1) begin fails++; $display("FAIL stuferr_r_error: got %b want 1", r_error); end
    tests++; if (rcving !== 1'b1) begin fails++; $display("FAIL stuferr_rcving_mid: got %b want 1", rcving); end
    send_eop();
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL stuferr_nwrites: got %0d want 0", got_q.size()); end
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL stuferr_done: got %0d want 0", done_cnt - d0); end
    tests++; if (rcving !== 1'b0) begin fails++; $display("FAIL stuferr_rcving_end: got %b want 0", rcving); end
    idle(10);
  endtask

  task automatic test_bad_sync();
    int d0;
    bits_q.delete();
    add_byte(8'hC0);
    stuff_stream();
    got_q.delete();
    d0 = done_cnt;
    send_wire(-1);
    tests++; if (r_error !== 1'b1) begin fails++; $display("FAIL badsync_r_error: got %b want 1", r_error); end
    bits_q.delete();
    add_byte(8'(($urandom)));
    stuff_stream();
    send_wire(-1);
    send_eop();
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL badsync_nwrites: got %0d want 0", got_q.size()); end
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL badsync_done: got %0d want 0", done_cnt - d0); end
    tests++; if (rcving !== 1'b0) begin fails++; $display("FAIL badsync_rcving: got %b want 0", rcving); end
    idle(10);
  endtask

  task automatic test_overflow();
    int d0;
    logic [7:0] b;
    fifo_full = 1'b1;
    bits_q.delete();
    add_byte(SYNC);
    add_byte(8'h3C);
    stuff_stream();
    got_q.delete();
    d0 = done_cnt;
    send_wire(-1);
    tests++; if (r_error !== 1'b1) begin fails++; $display("FAIL ovf_r_error: got %b want 1", r_error); end
    send_eop();
    fifo_full = 1'b0;
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL ovf_nwrites: got %0d want 0", got_q.size()); end
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL ovf_done: got %0d want 0", done_cnt - d0); end
    tests++; if (r_error !== 1'b1) begin fails++; $display("FAIL ovf_sticky: got %b want 1", r_error); end
    idle(10);
    b = 8'($urandom);
    exp_q = '{b};
    send_packet();
    tests++; if (sop_rerror !== 1'b0) begin fails++; $display("FAIL ovf_sop_clear: got %b want 0", sop_rerror); end
    tests++; if (got_q.size() != 1 || got_q[0] !== b) begin
      fails++; $display("FAIL ovf_recover: got %0d bytes want 1 byte %h", got_q.size(), b);
    end
    idle(10);
  endtask

  task automatic test_partial_and_reset();
    int d0;
    bits_q.delete();
    add_byte(SYNC);
    for (int i = 0; i < 4; i++) bits_q.push_back(1'($urandom));
    stuff_stream();
    got_q.delete();
    d0 = done_cnt;
    send_wire(-1);
    send_eop();
    tests++; if (r_error !== 1'b1) begin fails++; $display("FAIL partial_r_error: got %b want 1", r_error); end
    tests++; if (got_q.size() != 0) begin fails++; $display("FAIL partial_nwrites: got %0d want 0", got_q.size()); end
    tests++; if (done_cnt != d0) begin fails++; $display("FAIL partial_done: got %0d want 0", done_cnt - d0); end
    idle(10);
    // Reset in the middle of a data byte.
    bits_q.delete();
    add_byte(SYNC);
    add_byte(8'hC3);
    stuff_stream();
    send_wire(12);
    tests++; if (rcving !== 1'b1) begin fails++; $display("FAIL midrst_pre_rcving: got %b want 1", rcving); end
    n_rst = 1'b0;
    d_plus = 1'b1; d_minus = 1'b0;
    @(negedge clk);
    tests++; if ({w_enable, rcving, r_error, packet_done, w_data} !== 12'h000) begin
      fails++; $display("FAIL midrst_outputs: got we=%b rc=%b er=%b pd=%b wd=%h want all 0",
                        w_enable, rcving, r_error, packet_done, w_data);
    end
    @(negedge clk);
    n_rst = 1'b1;
    idle(20);
    exp_q = '{8'h5A};
    d0 = done_cnt;
    send_packet();
    tests++; if (got_q.size() != 1 || got_q[0] !== 8'h5A) begin
      fails++; $display("FAIL midrst_recover: got %0d bytes want 1 byte 5a", got_q.size());
    end
    tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL midrst_done: got %0d want 1", done_cnt - d0); end
    tests++; if (r_error !== 1'b0) begin fails++; $display("FAIL midrst_r_error: got %b want 0", r_error); end
    idle(10);
  endtask

  // Random packets with short, random gaps, covering back-to-back traffic.
  task automatic test_back_to_back();
    int d0;
    int len;
    for (int p = 0; p < 12; p++) begin
      len = $urandom_range(1, 4);
      exp_q.delete();
      for (int i = 0; i < len; i++) exp_q.push_back(8'($urandom));
      d0 = done_cnt;
      send_packet();
      tests++; if (got_q.size() != exp_q.size()) begin
        fails++; $display("FAIL rand%0d_nwrites: got %0d want %0d", p, got_q.size(), exp_q.size());
      end else begin
        for (int i = 0; i < len; i++) begin
          tests++; if (got_q[i] !== exp_q[i]) begin
            fails++; $display("FAIL rand%0d_byte%0d: got %h want %h", p, i, got_q[i], exp_q[i]);
          end
        end
      end
      tests++; if (done_cnt - d0 != 1) begin fails++; $display("FAIL rand%0d_done: got %0d want 1", p, done_cnt - d0); end
      tests++; if (r_error !== 1'b0) begin fails++; $display("FAIL rand%0d_r_error: got %b want 0", p, r_error); end
      idle($urandom_range(0, 16));
    end
  endtask

  initial begin
    n_rst     = 1'b0;
    d_plus    = 1'b1;
    d_minus   = 1'b0;
    fifo_full = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_stuffing();
    test_stuff_error();
    test_bad_sync();
    test_overflow();
    test_partial_and_reset();
    test_back_to_back();
    tests++; if (both_cnt != 0) begin fails++; $display("FAIL strobe_overlap: got %0d want 0", both_cnt); end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/usb_rx_byte_assembler.md
Name: usb_rx_byte_assembler

Overview:
Front end of the USB receiver. Recovers bit timing from the synchronized D+/D- pair, NRZI-decodes, removes stuffed bits, checks the SYNC field, and assembles LSB-first bytes. Each completed byte is pushed into the downstream packet FIFO with a one-cycle write strobe. It also detects EOP and flags framing, stuffing and overflow errors.

Parameters:
CLKS_PER_BIT, 8, system clocks per USB bit time (>=4, even)
SYNC_BYTE, 8'h80, expected SYNC value as assembled LSB-first (wire order 0000_0001)
STUFF_LIMIT, 6, consecutive decoded 1s after which the next bit is a stuff bit

Ports:
clk  input  1  system clock
n_rst  input  1  asynchronous active-low reset
d_plus  input  1  D+ line, already two-flop synchronized to clk
d_minus  input  1  D- line, already two-flop synchronized to clk
fifo_full  input  1  downstream FIFO full flag
w_enable  output  1  one-cycle write strobe to the FIFO
w_data  output  8  assembled byte; valid while w_enable=1
rcving  output  1  high from SOP detection until return to IDLE
r_error  output  1  sticky error flag
packet_done  output  1  one-cycle pulse on clean EOP

Behaviour:
- Reset: asynchronous, active low. All outputs 0. State IDLE. Previous-sample register = 1 (J). Edge register = 1. Bit timer = 0. Shift register = 0. Ones counter = 0.
- Line states: J = (D+=1, D-=0), K = (D+=0, D-=1), SE0 = (both 0). Both lines 1 is treated as SE0 for error purposes.
- SOP: in IDLE, a 1->0 transition of d_plus starts the bit timer and moves to SYNC. Entering SYNC sets rcving=1 and clears r_error.
- Bit timer: the first sample is taken CLKS_PER_BIT/2 clocks after the detected edge. Later samples follow every CLKS_PER_BIT clocks. Without the optional feature there is no realignment.
- NRZI decode at each sample: bit=1 if sampled d_plus equals the previous sample, otherwise 0. The previous sample then updates.
- Stuffing: after STUFF_LIMIT consecutive decoded 1s, the next bit is discarded and the ones counter clears. If that discarded bit is 1, go to ERR. Any decoded 0 clears the ones counter. The counter runs in SYNC and RECEIVE.
- Bits shift into bit 7 and move toward bit 0 (LSB-first). A 3-bit count tracks bits accepted.
- SYNC: after 8 accepted bits, go to RECEIVE if the byte equals SYNC_BYTE, otherwise go to ERR. An SE0 sample in SYNC goes to ERR.
- RECEIVE: on the 8th accepted bit, w_data is loaded and w_enable pulses for exactly 1 clock, on the cycle after the sample (latency 1 clk). If fifo_full=1 at that sample, there is no write and the block goes to ERR (overflow).
- RECEIVE with an SE0 sample: go to EOP if the bit count = 0. If the count is nonzero (partial byte), go to ERR and discard the byte.
- EOP: wait for the next sample.
  - J sample: pulse packet_done for 1 clk, drop rcving, return to IDLE.
  - SE0 sample: remain in EOP (SE0 allowed to last up to 2 bit times).
  - K sample, or a 3rd SE0: go to ERR.
- ERR: r_error=1 (sticky until the next SOP). No writes. Keep sampling. After an SE0 followed by a J sample, drop rcving and go to IDLE without packet_done.
- States: IDLE, SYNC, RECEIVE, EOP, ERR. Any other encoding goes to IDLE.
- w_enable and packet_done never assert in the same cycle. At most one write occurs per 8 bit times.
- Reset mid-packet: outputs clear immediately. The edge register is 1, so if d_plus is 0 on release a SYNC starts. That SYNC fails to ERR and recovers at the next SE0->J.

Optional Feature:
Macro RX_RESYNC_EN.
- Defined: in SYNC/RECEIVE, any d_plus transition reloads the bit timer so the next sample lands CLKS_PER_BIT/2 clocks later. This tolerates ±1 clk/bit drift.
- Undefined: the timer is free-running from SOP. Drift beyond ±CLKS_PER_BIT/2 cumulative corrupts data.

Test Plan:
- Idle J for 20 clks, then SYNC + byte 8'hA5 + SE0 x2 bits + J -> exactly one w_enable with w_data=8'hA5, then packet_done=1 for 1 clk, rcving=0, r_error=0.
- SYNC + 8'hFF + 8'h00 (one stuff bit inserted after six 1s) + EOP -> writes 8'hFF then 8'h00, no error, packet_done pulses.
- SYNC + six 1s, then a stuffed bit sent as 1 -> r_error=1, no w_enable, no packet_done; after SE0 then J, rcving=0 in IDLE.
- Wrong SYNC (wire 0000_0011 -> 8'hC0) -> r_error=1 after 8 bit times, zero writes.
- SYNC + 8'h3C with fifo_full=1 at the 8th sample -> no w_enable, r_error=1; next valid packet clears r_error on SOP.
- SYNC + 4 bits then SE0 -> r_error=1, no write. Assert n_rst mid-byte -> all outputs 0 next clk; a clean subsequent packet 8'h5A is received correctly.
